// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change path.
package vm_pkg;

   // Change dispenser FSM states, encoded to match the out_state port.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      EJECT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Coin chosen by the greedy selector.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      C1   = 2'd1,
      C05  = 2'd2,
      C025 = 2'd3
   } coin_t;

   // Coin values in quarter units.
   localparam int unsigned COIN_1   = 4;
   localparam int unsigned COIN_05  = 2;
   localparam int unsigned COIN_025 = 1;

   // Width that holds the largest coin value.
   localparam int unsigned COIN_VAL_W = 3;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin that fits the remaining amount and is in stock.
module coin_select
   import vm_pkg::*;
#(
   parameter int unsigned AMT_W = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic signed [AMT_W-1:0]      rem_i,
   input  logic        [CNT_W-1:0]      inv_1_i,
   input  logic        [CNT_W-1:0]      inv_05_i,
   input  logic        [CNT_W-1:0]      inv_025_i,
   output coin_t                        sel_o,
   output logic        [COIN_VAL_W-1:0] value_o
);

   localparam logic signed [AMT_W-1:0] REM_1   = AMT_W'(COIN_1);
   localparam logic signed [AMT_W-1:0] REM_05  = AMT_W'(COIN_05);
   localparam logic signed [AMT_W-1:0] REM_025 = AMT_W'(COIN_025);

   // Priority pick: $1, then $0.50, then $0.25; NONE when nothing fits.
   always_comb begin
      sel_o   = NONE;
      value_o = '0;
      if (rem_i >= REM_1 && inv_1_i != '0) begin
         sel_o   = C1;
         value_o = COIN_VAL_W'(COIN_1);
      end else if (rem_i >= REM_05 && inv_05_i != '0) begin
         sel_o   = C05;
         value_o = COIN_VAL_W'(COIN_05);
      end else if (rem_i >= REM_025 && inv_025_i != '0) begin
         sel_o   = C025;
         value_o = COIN_VAL_W'(COIN_025);
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an owed amount coin by coin through a hopper handshake,
// tracks coin inventories and reports any unpaid remainder.
module change_dispenser
   import vm_pkg::*;
#(
   parameter int unsigned AMT_W    = 16,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned INIT_1   = 20,
   parameter int unsigned INIT_05  = 20,
   parameter int unsigned INIT_025 = 40
) (
   input  logic                    in_clka,
   input  logic                    in_restart,
   input  logic                    in_start,
   input  logic signed [AMT_W-1:0] in_amount,
   input  logic                    in_hopper_ack,
   input  logic                    in_refill,
   output logic                    out_eject_1,
   output logic                    out_eject_05,
   output logic                    out_eject_025,
   output logic                    out_busy,
   output logic                    out_done,
   output logic                    out_short,
   output logic signed [AMT_W-1:0] out_remaining,
   output logic        [CNT_W-1:0] out_inv_1,
   output logic        [CNT_W-1:0] out_inv_05,
   output logic        [CNT_W-1:0] out_inv_025,
   output logic        [1:0]       out_state
);

   localparam logic [CNT_W-1:0] INV_1_RST   = CNT_W'(INIT_1);
   localparam logic [CNT_W-1:0] INV_05_RST  = CNT_W'(INIT_05);
   localparam logic [CNT_W-1:0] INV_025_RST = CNT_W'(INIT_025);

   state_t                    state_q, state_d;
   logic signed [AMT_W-1:0]   rem_q, rem_d;
   coin_t                     coin_q, coin_d;
   logic [COIN_VAL_W-1:0]     val_q, val_d;
   logic [2:0]                eject_q, eject_d;   // {$1, $0.50, $0.25}
   logic                      short_q, short_d;
   logic signed [AMT_W-1:0]   remaining_q, remaining_d;
   logic [CNT_W-1:0]          inv_1_q, inv_1_d;
   logic [CNT_W-1:0]          inv_05_q, inv_05_d;
   logic [CNT_W-1:0]          inv_025_q, inv_025_d;

   coin_t                     pick;
   logic [COIN_VAL_W-1:0]     pick_val;

   coin_select #(
      .AMT_W (AMT_W),
      .CNT_W (CNT_W)
   ) u_coin_select (
      .rem_i     (rem_q),
      .inv_1_i   (inv_1_q),
      .inv_05_i  (inv_05_q),
      .inv_025_i (inv_025_q),
      .sel_o     (pick),
      .value_o   (pick_val)
   );

   // State and datapath registers with synchronous restart.
   always_ff @(posedge in_clka) begin
      if (in_restart) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         coin_q      <= NONE;
         val_q       <= '0;
         eject_q     <= '0;
         short_q     <= 1'b0;
         remaining_q <= '0;
         inv_1_q     <= INV_1_RST;
         inv_05_q    <= INV_05_RST;
         inv_025_q   <= INV_025_RST;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         coin_q      <= coin_d;
         val_q       <= val_d;
         eject_q     <= eject_d;
         short_q     <= short_d;
         remaining_q <= remaining_d;
         inv_1_q     <= inv_1_d;
         inv_05_q    <= inv_05_d;
         inv_025_q   <= inv_025_d;
      end
   end

   // Next-state logic: start/refill in IDLE, greedy pick, hopper handshake, result report.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      coin_d      = coin_q;
      val_d       = val_q;
      eject_d     = eject_q;
      short_d     = short_q;
      remaining_d = remaining_q;
      inv_1_d     = inv_1_q;
      inv_05_d    = inv_05_q;
      inv_025_d   = inv_025_q;

      unique case (state_q)
         IDLE: begin
            if (in_refill) begin
               inv_1_d   = INV_1_RST;
               inv_05_d  = INV_05_RST;
               inv_025_d = INV_025_RST;
            end
            if (in_start) begin
               short_d     = 1'b0;
               remaining_d = '0;
               if (in_amount > 0) begin
                  rem_d   = in_amount;
                  state_d = SELECT;
               end else begin
                  // Non-positive amounts owe nothing.
                  rem_d   = '0;
                  state_d = DONE;
               end
            end
         end

         SELECT: begin
            if (pick != NONE) begin
               coin_d  = pick;
               val_d   = pick_val;
               eject_d = {pick == C1, pick == C05, pick == C025};
               state_d = EJECT;
            end else begin
               short_d     = (rem_q != '0);
               remaining_d = rem_q;
               state_d     = DONE;
            end
         end

         EJECT: begin
            if (in_hopper_ack) begin
               eject_d = '0;
               rem_d   = rem_q - $signed(AMT_W'(val_q));
               case (coin_q)
                  C1:      if (inv_1_q != '0)   inv_1_d   = inv_1_q - CNT_W'(1);
                  C05:     if (inv_05_q != '0)  inv_05_d  = inv_05_q - CNT_W'(1);
                  C025:    if (inv_025_q != '0) inv_025_d = inv_025_q - CNT_W'(1);
                  default: ;
               endcase
               state_d = SELECT;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Output mapping.
   always_comb begin
      out_eject_1   = eject_q[2];
      out_eject_05  = eject_q[1];
      out_eject_025 = eject_q[0];
      out_busy      = (state_q != IDLE);
      out_done      = (state_q == DONE);
      out_short     = short_q;
      out_remaining = remaining_q;
      out_inv_1     = inv_1_q;
      out_inv_05    = inv_05_q;
      out_inv_025   = inv_025_q;
      out_state     = state_q;
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: three instances with different inventories,
// exercised one at a time; a monitor checks every eject and done against the queue.
module tb_change_dispenser;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic               start  [3];
   logic               refill [3];
   logic               ack    [3];
   logic signed [15:0] amount [3];

   logic               e1 [3], e05 [3], e025 [3];
   logic               busy [3], done [3], shrt [3];
   logic [15:0]        remn [3];
   logic [7:0]         inv1 [3], inv05 [3], inv025 [3];
   logic [1:0]         st [3];

   change_dispenser u0 (
      .in_clka (clk), .in_restart (rst), .in_start (start[0]), .in_amount (amount[0]),
      .in_hopper_ack (ack[0]), .in_refill (refill[0]),
      .out_eject_1 (e1[0]), .out_eject_05 (e05[0]), .out_eject_025 (e025[0]),
      .out_busy (busy[0]), .out_done (done[0]), .out_short (shrt[0]),
      .out_remaining (remn[0]), .out_inv_1 (inv1[0]), .out_inv_05 (inv05[0]),
      .out_inv_025 (inv025[0]), .out_state (st[0])
   );

   change_dispenser #(.INIT_1 (0)) u1 (
      .in_clka (clk), .in_restart (rst), .in_start (start[1]), .in_amount (amount[1]),
      .in_hopper_ack (ack[1]), .in_refill (refill[1]),
      .out_eject_1 (e1[1]), .out_eject_05 (e05[1]), .out_eject_025 (e025[1]),
      .out_busy (busy[1]), .out_done (done[1]), .out_short (shrt[1]),
      .out_remaining (remn[1]), .out_inv_1 (inv1[1]), .out_inv_05 (inv05[1]),
      .out_inv_025 (inv025[1]), .out_state (st[1])
   );

   change_dispenser #(.INIT_05 (1), .INIT_025 (0)) u2 (
      .in_clka (clk), .in_restart (rst), .in_start (start[2]), .in_amount (amount[2]),
      .in_hopper_ack (ack[2]), .in_refill (refill[2]),
      .out_eject_1 (e1[2]), .out_eject_05 (e05[2]), .out_eject_025 (e025[2]),
      .out_busy (busy[2]), .out_done (done[2]), .out_short (shrt[2]),
      .out_remaining (remn[2]), .out_inv_1 (inv1[2]), .out_inv_05 (inv05[2]),
      .out_inv_025 (inv025[2]), .out_state (st[2])
   );

   typedef struct packed {
      logic [1:0]  id;
      logic        kind;   // 0 = coin eject, 1 = done
      logic [2:0]  coin;   // {$1, $0.50, $0.25}
      logic        sh;
      logic [15:0] rem;
      logic [7:0]  i1;
      logic [7:0]  i05;
      logic [7:0]  i025;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   function automatic void exp_coin(input int i, input logic [2:0] c);
      exp_t e;
      e = '0;
      e.id = 2'(i);
      e.kind = 1'b0;
      e.coin = c;
      sb.push_back(e);
   endfunction

   function automatic void exp_done(input int i, input logic sh, input int rem,
                                    input int a, input int b, input int c);
      exp_t e;
      e = '0;
      e.id = 2'(i);
      e.kind = 1'b1;
      e.sh = sh;
      e.rem = 16'(rem);
      e.i1 = 8'(a);
      e.i05 = 8'(b);
      e.i025 = 8'(c);
      sb.push_back(e);
   endfunction

   // Monitor: one event per eject rising edge and per done pulse, on every instance.
   logic [2:0] prev [3];
   logic [2:0] cur;
   exp_t       got;
   initial for (int k = 0; k < 3; k++) prev[k] = 3'b000;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         cur = {e1[i], e05[i], e025[i]};
         if ((cur != 3'b000 && prev[i] == 3'b000) || done[i]) begin
            if (sb.size() == 0) begin
               chk("unexpected event", 32'(i), 32'(99));
            end else begin
               got = sb.pop_front();
               chk("event instance", 32'(i), 32'(got.id));
               chk("event kind", 32'(done[i]), 32'(got.kind));
               if (got.kind == 1'b0) begin
                  chk("coin ejected", 32'(cur), 32'(got.coin));
               end else begin
                  chk("short", 32'(shrt[i]), 32'(got.sh));
                  chk("remaining", 32'(remn[i]), 32'(got.rem));
                  chk("inv_1", 32'(inv1[i]), 32'(got.i1));
                  chk("inv_05", 32'(inv05[i]), 32'(got.i05));
                  chk("inv_025", 32'(inv025[i]), 32'(got.i025));
               end
            end
         end
         prev[i] = cur;
      end
   end

   task automatic kick(input int i, input int amt, input logic rf);
      @(negedge clk);
      start[i]  = 1'b1;
      amount[i] = 16'(amt);
      refill[i] = rf;
      @(posedge clk);
      #1;
      start[i]  = 1'b0;
      refill[i] = 1'b0;
   endtask

   // Cycles counted from the edge that sampled start; bounded.
   task automatic wait_done(input int i, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[i] && n < 60);
   endtask

   int n;

   initial begin
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0; refill[k] = 1'b0; ack[k] = 1'b0; amount[k] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("reset state", 32'(st[0]), 32'(0));
      chk("reset ejects", 32'({e1[0], e05[0], e025[0]}), 32'(0));
      chk("reset busy/done/short", 32'({busy[0], done[0], shrt[0]}), 32'(0));
      chk("reset remaining", 32'(remn[0]), 32'(0));
      chk("reset inv", 32'({inv1[0], inv05[0], inv025[0]}), {8'd0, 8'd20, 8'd20, 8'd40});

      // 7 quarters: $1, $0.50, $0.25
      ack[0] = 1'b1;
      exp_coin(0, 3'b100); exp_coin(0, 3'b010); exp_coin(0, 3'b001);
      exp_done(0, 1'b0, 0, 19, 19, 39);
      kick(0, 7, 1'b0);
      wait_done(0, n);
      chk("amount 7 done cycle", 32'(n), 32'(8));
      ack[0] = 1'b0;

      // No $1 coins: 8 quarters as four $0.50
      ack[1] = 1'b1;
      for (int k = 0; k < 4; k++) exp_coin(1, 3'b010);
      exp_done(1, 1'b0, 0, 0, 16, 40);
      kick(1, 8, 1'b0);
      wait_done(1, n);
      chk("no-$1 done cycle", 32'(n), 32'(10));
      ack[1] = 1'b0;

      // One $0.50, no quarters: 3 owed leaves 1 unpaid
      ack[2] = 1'b1;
      exp_coin(2, 3'b010);
      exp_done(2, 1'b1, 1, 20, 0, 0);
      kick(2, 3, 1'b0);
      wait_done(2, n);
      chk("short done cycle", 32'(n), 32'(4));
      ack[2] = 1'b0;

      // Zero and negative amounts
      exp_done(0, 1'b0, 0, 19, 19, 39);
      kick(0, 0, 1'b0);
      wait_done(0, n);
      chk("amount 0 done cycle", 32'(n), 32'(1));
      exp_done(0, 1'b0, 0, 19, 19, 39);
      kick(0, -5, 1'b0);
      wait_done(0, n);
      chk("amount -5 done cycle", 32'(n), 32'(1));

      // Delayed ack, ack during SELECT, start during EJECT
      exp_coin(0, 3'b100);
      exp_done(0, 1'b0, 0, 18, 19, 39);
      kick(0, 4, 1'b0);
      @(negedge clk);
      chk("select state", 32'(st[0]), 32'(1));
      ack[0] = 1'b1;
      @(negedge clk);
      chk("ack in select ignored", 32'(st[0]), 32'(2));
      chk("eject up", 32'({e1[0], e05[0], e025[0]}), 32'(3'b100));
      ack[0] = 1'b0;
      start[0] = 1'b1;
      amount[0] = 16'sd8;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start[0] = 1'b0;
         chk("eject held", 32'({e1[0], e05[0], e025[0]}), 32'(3'b100));
         chk("waiting in eject", 32'(st[0]), 32'(2));
      end
      ack[0] = 1'b1;
      wait_done(0, n);
      chk("delayed ack done cycle", 32'(n), 32'(2));
      ack[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("start in eject ignored", 32'(busy[0]), 32'(0));

      // Restart mid-EJECT
      exp_coin(0, 3'b100);
      kick(0, 4, 1'b0);
      repeat (2) @(negedge clk);
      chk("in eject before restart", 32'(st[0]), 32'(2));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("restart state", 32'(st[0]), 32'(0));
      chk("restart ejects", 32'({e1[0], e05[0], e025[0]}), 32'(0));
      chk("restart inv", 32'({inv1[0], inv05[0], inv025[0]}), {8'd0, 8'd20, 8'd20, 8'd40});
      chk("restart no done", 32'(done[0]), 32'(0));
      repeat (3) @(negedge clk);

      // Drain some stock, then refill together with start
      ack[0] = 1'b1;
      exp_coin(0, 3'b100); exp_coin(0, 3'b010); exp_coin(0, 3'b001);
      exp_done(0, 1'b0, 0, 19, 19, 39);
      kick(0, 7, 1'b0);
      wait_done(0, n);
      chk("pre-refill done cycle", 32'(n), 32'(8));
      exp_coin(0, 3'b100); exp_coin(0, 3'b001);
      exp_done(0, 1'b0, 0, 19, 20, 39);
      kick(0, 5, 1'b1);
      wait_done(0, n);
      chk("refill+start done cycle", 32'(n), 32'(6));
      ack[0] = 1'b0;

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 32'(sb.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change after a vending transaction by breaking the owed amount into $1, $0.50 and $0.25 coins, biggest coins first. It drives one coin-hopper eject request at a time and waits for the hopper to acknowledge each coin. It keeps a running inventory of each coin type and flags a short payment when the inventory cannot cover the amount owed. It sits downstream of the vending-machine top level and consumes that block's change amount at the end of a transaction.

## Interface
Parameters:
- AMT_W, 16, width of amount and remaining buses (signed)
- CNT_W, 8, width of each inventory counter
- INIT_1, 20, reset/refill count of $1 coins
- INIT_05, 20, reset/refill count of $0.50 coins
- INIT_025, 40, reset/refill count of $0.25 coins

Ports:
- in_clka  in  1  clock; single clock domain, rising edge
- in_restart  in  1  reset; synchronous, active-high
- in_start  in  1  begin payout; sampled only in IDLE
- in_amount  in  AMT_W  signed change owed, in quarter units (1 = $0.25, 4 = $1)
- in_hopper_ack  in  1  hopper confirms the requested coin was ejected
- in_refill  in  1  reload all inventories to their INIT values; honoured only in IDLE
- out_eject_1 / out_eject_05 / out_eject_025  out  1 each  eject request; at most one high; held until ack
- out_busy  out  1  high in any state other than IDLE
- out_done  out  1  one-cycle pulse when payout ends
- out_short  out  1  valid with out_done and held until next start; 1 = amount not fully paid
- out_remaining  out  AMT_W  unpaid quarters; held until next start
- out_inv_1 / out_inv_05 / out_inv_025  out  CNT_W each  current coin counts
- out_state  out  2  0 IDLE, 1 SELECT, 2 EJECT, 3 DONE

## Operation
Reset values:
- state IDLE
- all eject outputs, out_busy, out_done and out_short are 0
- out_remaining is 0
- inventories load their INIT values

State machine:
- **IDLE**
  - in_start with in_amount > 0: latch rem = in_amount, go to SELECT.
  - in_start with in_amount ≤ 0: rem = 0, go straight to DONE. Negative amounts count as zero owed.
- **SELECT** (greedy pick, in priority order):
  - rem ≥ 4 and inv_1 > 0: pick $1.
  - else rem ≥ 2 and inv_05 > 0: pick $0.50.
  - else rem ≥ 1 and inv_025 > 0: pick $0.25.
  - If a coin is picked, go to EJECT. If nothing is picked (rem = 0, or no usable coin), go to DONE.
- **EJECT**
  - The chosen eject output is high for the whole state.
  - On in_hopper_ack: decrement that coin's inventory, subtract its value from rem (4/2/1), go to SELECT.
- **DONE**
  - out_done = 1 for this one cycle.
  - out_short = (rem ≠ 0). out_remaining = rem.
  - Go to IDLE.

Arithmetic:
- rem is signed AMT_W and never goes below 0, because a coin is only picked when rem ≥ its value.
- An inventory only decrements when it is > 0, so counters never wrap.

## Timing
- Pay-out time for N coins with ack held high: out_done is high in cycle 2N+2 after the edge that samples in_start. Cycle-level breakdown:
  - start → SELECT: 1 cycle.
  - SELECT → EJECT: 1 cycle.
  - EJECT with ack → SELECT: 1 cycle.
  - Final SELECT → DONE: 1 cycle.
  - DONE → IDLE: 1 cycle.
- Eject request rules:
  - The request is registered and rises on the cycle the block enters EJECT.
  - It drops on the edge that samples ack.
  - Ack in any state other than EJECT is ignored.
  - Ack held high across several cycles counts once per EJECT visit.
- Start and refill rules:
  - in_start while busy is ignored; it is not queued.
  - in_refill outside IDLE is ignored.
  - in_start and in_refill in the same IDLE cycle: both are taken, and SELECT sees the refilled counts.
- Reset mid-payout: on the next edge the block returns to IDLE, eject requests drop, inventories reload, and no out_done is generated.

## Structure
- Shared package vm_pkg holds:
  - the state enum (IDLE/SELECT/EJECT/DONE = 0..3);
  - coin value constants (COIN_1 = 4, COIN_05 = 2, COIN_025 = 1);
  - the coin-select enum (NONE, C1, C05, C025).
- One sub-module, coin_select: purely combinational greedy priority pick. Takes rem and the three inventories; returns the selected coin and its value.
- The FSM, rem register and inventory counters stay in change_dispenser.

## Test plan
- Reset, then in_start with amount = 7 and ack tied high:
  - ejects $1, $0.50, $0.25 in that order;
  - out_done in cycle 8;
  - out_short = 0, out_remaining = 0;
  - inventories end at 19/19/39.
- INIT_1 = 0, amount = 8:
  - four $0.50 coins ejected;
  - out_short = 0;
  - inv_05 drops by 4.
- INIT_05 = 1, INIT_025 = 0, amount = 3:
  - one $0.50 coin ejected;
  - out_done with out_short = 1, out_remaining = 1.
- amount = 0, then amount = -5:
  - each gives out_done 1 cycle after start;
  - no ejects, out_short = 0.
- Ack delayed 3 cycles and a second in_start pulsed during EJECT:
  - eject request held steady through the wait;
  - second start ignored;
  - ack seen during SELECT has no effect.
- in_restart asserted while in EJECT:
  - next cycle is IDLE with all ejects 0;
  - inventories back at INIT;
  - no out_done.
  - Then in_refill together with in_start in IDLE: payout runs using the refilled counts.
